instr_fetch: RTL and testbench

Instruction fetch unit feeding the CPU controller. Holds the program counter, reads 23-bit instruction words from instruction memory over a req/ack handshake, latches each word into `code` and pulses `start` to launch the controller. It then waits for the controller's `inc_pc` or `branch` completion signal, updates the PC and fetches the next word.

---
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch unit. Holds the program counter and reads
//            instruction words over a req/ack handshake. It latches each word
//            into code and pulses start. It then waits for the controller to
//            report inc_pc or branch, and fetches again.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
   parameter int              ADDR_W   = 8,
   parameter int              INSTR_W  = 23,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               inc_pc,
   input  logic               branch,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] code,
   output logic               start,
   output logic [ADDR_W-1:0]  pc,
   output logic [15:0]        retired,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      EXEC  = 2'd3
   } state_t;

   state_t state, state_nxt;

   // The controller reports completion with either signal. Branch takes
   // priority when both are present.
   logic done;
   assign done = inc_pc | branch;

   // State register; reset is asynchronous so a pending request drops at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic. Dropping run never aborts an instruction in flight.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run)     state_nxt = FETCH;
         FETCH:   if (mem_ack) state_nxt = ISSUE;
         ISSUE:                state_nxt = EXEC;
         EXEC:    if (done)    state_nxt = run ? FETCH : IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   // Datapath: latch the fetched word and raise start with a single register.
   // Then update pc and retired when the controller reports completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= RESET_PC;
         code    <= '0;
         start   <= 1'b0;
         retired <= 16'd0;
      end else begin
         start <= (state == FETCH) && mem_ack;
         if ((state == FETCH) && mem_ack)
            code <= mem_rdata;
         if ((state == EXEC) && done) begin
            pc      <= branch ? branch_target : pc + 1'b1;
            retired <= retired + 16'd1;
         end
      end
   end

   // pc only changes in EXEC, so mem_addr holds steady during a pending
   // request.
   assign mem_req  = (state == FETCH);
   assign mem_addr = pc;
   assign busy     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed self-checking bench for instr_fetch. Words returned by
//            the memory model are queued and then compared against code when
//            start fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 23;

   logic               clk = 1'b0;
   logic               rst;
   logic               run;
   logic               inc_pc;
   logic               branch;
   logic [ADDR_W-1:0]  branch_target;
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_rdata;
   logic [INSTR_W-1:0] code;
   logic               start;
   logic [ADDR_W-1:0]  pc;
   logic [15:0]        retired;
   logic               busy;

   int vectors = 0;
   int errors  = 0;
   logic [INSTR_W-1:0] exp_q[$];
   logic [INSTR_W-1:0] exp_code;
   logic [15:0]        exp_ret;

   instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .run(run), .inc_pc(inc_pc), .branch(branch),
      .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .code(code), .start(start),
      .pc(pc), .retired(retired), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered just after the edge that put the DUT in FETCH. The ack is held
   // low for lat cycles. On return the DUT is in EXEC.
   task automatic do_fetch(input int lat, input logic [INSTR_W-1:0] data,
                           input logic [ADDR_W-1:0] addr);
      for (int i = 0; i < lat; i++) begin
         chk("wait_req", {31'd0, mem_req}, 32'd1);
         chk("wait_addr", {24'd0, mem_addr}, {24'd0, addr});
         chk("wait_start", {31'd0, start}, 32'd0);
         tick();
      end
      chk("fetch_req", {31'd0, mem_req}, 32'd1);
      chk("fetch_addr", {24'd0, mem_addr}, {24'd0, addr});
      mem_ack   = 1'b1;
      mem_rdata = data;
      exp_q.push_back(data);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("issue_start", {31'd0, start}, 32'd1);
      chk("issue_req", {31'd0, mem_req}, 32'd0);
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         exp_code = exp_q.pop_front();
         chk("issue_code", {9'd0, code}, {9'd0, exp_code});
      end
      tick();
      chk("exec_start", {31'd0, start}, 32'd0);
      chk("exec_busy", {31'd0, busy}, 32'd1);
   endtask

   // Issues one completion in EXEC and checks the updated pc and retired.
   task automatic do_exec(input logic inc, input logic br,
                          input logic [ADDR_W-1:0] tgt, input logic [ADDR_W-1:0] exp_pc);
      inc_pc = inc;
      branch = br;
      branch_target = tgt;
      tick();
      inc_pc = 1'b0;
      branch = 1'b0;
      branch_target = '0;
      exp_ret = exp_ret + 16'd1;
      chk("exec_pc", {24'd0, pc}, {24'd0, exp_pc});
      chk("exec_retired", {16'd0, retired}, {16'd0, exp_ret});
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; inc_pc = 1'b0; branch = 1'b0;
      branch_target = '0; mem_ack = 1'b0; mem_rdata = '0;
      exp_ret = 16'd0;
      #1;
      chk("rst_pc", {24'd0, pc}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_code", {9'd0, code}, 32'd0);
      chk("rst_start", {31'd0, start}, 32'd0);
      chk("rst_retired", {16'd0, retired}, 32'd0);
      chk("rst_addr", {24'd0, mem_addr}, 32'd0);
      tick(); tick();
      rst = 1'b0;

      // Reset then run, single-cycle memory.
      run = 1'b1;
      tick();
      do_fetch(0, 23'h1A5A5A, 8'h00);
      do_exec(1'b1, 1'b0, 8'h00, 8'h01);
      chk("next_addr", {24'd0, mem_addr}, 32'd1);

      // Variable latency: ack held low for 5 cycles.
      do_fetch(5, 23'h012345, 8'h01);
      do_exec(1'b1, 1'b0, 8'h00, 8'h02);

      // Branch to 0x10, then branch and inc_pc together.
      do_fetch(0, 23'h7FFFFF, 8'h02);
      do_exec(1'b0, 1'b1, 8'h10, 8'h10);
      do_fetch(1, 23'h000001, 8'h10);
      do_exec(1'b1, 1'b1, 8'h42, 8'h42);
      chk("branch_addr", {24'd0, mem_addr}, 32'h42);

      // PC wrap-around.
      do_fetch(0, 23'h2AAAAA, 8'h42);
      do_exec(1'b0, 1'b1, 8'hFF, 8'hFF);
      do_fetch(2, 23'h555555, 8'hFF);
      do_exec(1'b1, 1'b0, 8'h00, 8'h00);
      chk("wrap_addr", {24'd0, mem_addr}, 32'h00);

      // Completion signals outside EXEC are ignored.
      inc_pc = 1'b1; branch = 1'b1; branch_target = 8'h33;
      tick();
      inc_pc = 1'b0; branch = 1'b0; branch_target = '0;
      chk("ign_pc", {24'd0, pc}, 32'h00);
      chk("ign_retired", {16'd0, retired}, {16'd0, exp_ret});

      // Dropping run during FETCH: the instruction completes, then the DUT
      // goes to IDLE.
      run = 1'b0;
      do_fetch(0, 23'h13579B, 8'h00);
      chk("drop_busy_exec", {31'd0, busy}, 32'd1);
      tick();
      chk("drop_wait_exec", {31'd0, busy}, 32'd1);
      do_exec(1'b1, 1'b0, 8'h00, 8'h01);
      chk("drop_idle_busy", {31'd0, busy}, 32'd0);
      chk("drop_idle_req", {31'd0, mem_req}, 32'd0);

      // An ack in IDLE is ignored.
      mem_ack = 1'b1; mem_rdata = 23'h0F0F0F;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      chk("idle_ack_code", {9'd0, code}, 32'h13579B);
      chk("idle_ack_start", {31'd0, start}, 32'd0);

      // Reach pc=0x07 and assert reset between edges during the fetch.
      run = 1'b1;
      tick();
      do_fetch(0, 23'h246802, 8'h01);
      do_exec(1'b0, 1'b1, 8'h07, 8'h07);
      chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_req", {31'd0, mem_req}, 32'd0);
      chk("arst_start", {31'd0, start}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_pc", {24'd0, pc}, 32'd0);
      chk("arst_code", {9'd0, code}, 32'd0);
      exp_ret = 16'd0;
      chk("arst_retired", {16'd0, retired}, 32'd0);
      tick();
      rst = 1'b0; run = 1'b0;
      mem_ack = 1'b1; mem_rdata = 23'h3C3C3C;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      chk("late_ack_code", {9'd0, code}, 32'd0);
      chk("late_ack_start", {31'd0, start}, 32'd0);
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // Guards against a hang if the directed sequence stalls.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
